teclado_entrada_ctrl: RTL and testbench

Sequencer that sits downstream of the 4x4 matrix keypad scanner. It turns the scanner's key_valid/bcd_out stream into multi-digit numeric entries. Editing keys are supported: '*' clears, 'A' deletes the last digit, '#' commits. A committed entry is delivered to the consumer over a valid/ready handshake. An idle timeout abandons a stale entry.

---
 rtl/teclado_pkg.sv | 18 +
 rtl/teclado_evt_detect.sv | 25 ++
 rtl/teclado_entrada_ctrl.sv | 154 +++++++++++++++
 tb/tb_teclado_entrada_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - key codes, state encoding and key classification for the keypad entry sequencer
package teclado_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    COMMIT
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/teclado_evt_detect.sv
// rtl/teclado_evt_detect.sv - rising-edge key event detector with key code capture
module teclado_evt_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] bcd_in,
  output logic       evt,
  output logic [3:0] key_code
);

  logic key_valid_q;

  // Track the previous key_valid level; resets high so a key held through reset never fires
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b1;
    end else begin
      key_valid_q <= key_valid;
    end
  end

  assign evt      = key_valid & ~key_valid_q;
  assign key_code = bcd_in;

endmodule

// File: rtl/teclado_entrada_ctrl.sv
// rtl/teclado_entrada_ctrl.sv - multi-digit keypad entry sequencer with edit keys, commit handshake and idle timeout
module teclado_entrada_ctrl
  import teclado_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_valid,
  input  logic [3:0]                        bcd_in,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [4*MAX_DIGITS-1:0]           out_digits,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   out_count,
  output logic                              busy,
  output logic                              overflow,
  output logic                              timeout
);

  localparam int DW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] CNT_FULL   = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          evt;
  logic [3:0]    key_code;

  state_t        state_q, state_n;
  logic [DW-1:0] buf_q, buf_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          valid_n;
  logic [DW-1:0] digits_n;
  logic [CW-1:0] count_n;
  logic          overflow_n;
  logic          timeout_n;

  teclado_evt_detect u_evt_detect (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .bcd_in    (bcd_in),
    .evt       (evt),
    .key_code  (key_code)
  );

  // State, entry buffer, idle timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      out_valid  <= 1'b0;
      out_digits <= '0;
      out_count  <= '0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_n;
      buf_q      <= buf_n;
      cnt_q      <= cnt_n;
      timer_q    <= timer_n;
      out_valid  <= valid_n;
      out_digits <= digits_n;
      out_count  <= count_n;
      overflow   <= overflow_n;
      timeout    <= timeout_n;
    end
  end

  // Next-state logic: key handling per state, timer expiry, commit handshake
  always_comb begin
    state_n    = state_q;
    buf_n      = buf_q;
    cnt_n      = cnt_q;
    timer_n    = timer_q;
    valid_n    = out_valid;
    digits_n   = out_digits;
    count_n    = out_count;
    overflow_n = 1'b0;
    timeout_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_n = '0;
        if (evt && is_digit(key_code)) begin
          buf_n   = DW'(key_code);
          cnt_n   = CW'(1);
          state_n = ENTRY;
        end
      end

      ENTRY: begin
        if (evt) begin
          // Any key, even an ignored letter, counts as activity
          timer_n = '0;
          if (is_digit(key_code)) begin
            if (cnt_q < CNT_FULL) begin
              buf_n = (buf_q << 4) | DW'(key_code);
              cnt_n = cnt_q + CW'(1);
            end else begin
              overflow_n = 1'b1;
            end
          end else if (key_code == KEY_A) begin
            buf_n = buf_q >> 4;
            cnt_n = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_n = IDLE;
            end
          end else if (key_code == KEY_STAR) begin
            buf_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
          end else if (key_code == KEY_HASH) begin
            digits_n = buf_q;
            count_n  = cnt_q;
            valid_n  = 1'b1;
            state_n  = COMMIT;
          end
        end else if (timer_q == TIMER_LAST) begin
          buf_n     = '0;
          cnt_n     = '0;
          timer_n   = '0;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end

      COMMIT: begin
        // Keys are dropped here; the edge detector keeps tracking key_valid on its own
        timer_n = '0;
        if (out_ready) begin
          valid_n = 1'b0;
          buf_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_teclado_entrada_ctrl.sv
// tb/tb_teclado_entrada_ctrl.sv - directed and randomized bench for teclado_entrada_ctrl against a digit-queue model
module tb_teclado_entrada_ctrl;

  localparam int MAXD = 4;
  localparam int TO   = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  bcd_in;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_digits;
  logic [2:0]  out_count;
  logic        busy;
  logic        overflow;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = waiting, 1 = collecting, 2 = delivering
  int          m_mode;
  int          q[$];
  int          m_prev;
  longint      cyc;
  longint      last_act;
  logic        m_valid;
  logic [15:0] m_digits;
  logic [2:0]  m_count;
  logic        m_ovf;
  logic        m_to;
  int          ovf_total;
  int          to_total;
  bit          rand_ready;

  teclado_entrada_ctrl #(
    .MAX_DIGITS     (MAXD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .bcd_in     (bcd_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digits (out_digits),
    .out_count  (out_count),
    .busy       (busy),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack_digits();
    logic [15:0] v = '0;
    foreach (q[i]) v = (v << 4) | 16'(q[i]);
    return v;
  endfunction

  task automatic model_step();
    bit evt;
    int code;
    evt  = key_valid && (m_prev == 0);
    code = int'(bcd_in);
    if (rst) begin
      m_mode = 0; q.delete(); m_prev = 1;
      m_valid = 0; m_digits = '0; m_count = '0; m_ovf = 0; m_to = 0;
      cyc++;
      return;
    end
    m_ovf = 0;
    m_to  = 0;
    case (m_mode)
      0: if (evt && code <= 9) begin
        q.delete(); q.push_back(code); m_mode = 1; last_act = cyc;
      end
      1: begin
        if (evt) begin
          last_act = cyc;
          if (code <= 9) begin
            if (q.size() < MAXD) q.push_back(code);
            else begin m_ovf = 1; ovf_total++; end
          end else if (code == 10) begin
            void'(q.pop_back());
            if (q.size() == 0) m_mode = 0;
          end else if (code == 14) begin
            q.delete(); m_mode = 0;
          end else if (code == 15) begin
            m_valid = 1; m_digits = pack_digits(); m_count = 3'(q.size()); m_mode = 2;
          end
        end else if (cyc - last_act == TO) begin
          q.delete(); m_to = 1; to_total++; m_mode = 0;
        end
      end
      default: if (out_ready) begin
        m_valid = 0; q.delete(); m_mode = 0;
      end
    endcase
    m_prev = key_valid ? 1 : 0;
    cyc++;
  endtask

  task automatic tick();
    if (rand_ready) out_ready = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_valid",  32'(out_valid),  32'(m_valid));
    chk("out_digits", 32'(out_digits), 32'(m_digits));
    chk("out_count",  32'(out_count),  32'(m_count));
    chk("busy",       32'(busy),       32'(m_mode != 0));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("timeout",    32'(timeout),    32'(m_to));
  endtask

  task automatic press(input logic [3:0] code, input int hi, input int lo);
    bcd_in    = code;
    key_valid = 1'b1;
    tick();
    for (int i = 1; i < hi; i++) begin
      bcd_in = 4'($urandom_range(0, 15));
      tick();
    end
    key_valid = 1'b0;
    for (int i = 0; i < lo; i++) begin
      bcd_in = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic key(input logic [3:0] code);
    press(code, 3, 3);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int ovf_before;
  int to_before;
  logic [3:0] rcode;

  initial begin
    m_mode = 0; m_prev = 1; cyc = 0; last_act = 0;
    m_valid = 0; m_digits = '0; m_count = '0; m_ovf = 0; m_to = 0;
    ovf_total = 0; to_total = 0; rand_ready = 0;
    rst = 1'b1; key_valid = 1'b0; bcd_in = 4'h0; out_ready = 1'b0;
    tick();
    tick();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    tick();

    // 1: basic commit with delayed consumer
    key(4'h1); key(4'h2); key(4'h3); key(4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1_hold_valid",  32'(out_valid),  32'd1);
      chk("s1_hold_digits", 32'(out_digits), 32'h0123);
      chk("s1_hold_count",  32'(out_count),  32'd3);
    end
    handshake();
    chk("s1_after_valid", 32'(out_valid), 32'd0);
    chk("s1_after_busy",  32'(busy),      32'd0);
    chk("s1_kept_digits", 32'(out_digits), 32'h0123);

    // 2: overflow on fifth digit
    ovf_before = ovf_total;
    key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5); key(4'hF);
    chk("s2_ovf_pulses", 32'(ovf_total - ovf_before), 32'd1);
    chk("s2_digits", 32'(out_digits), 32'h1234);
    chk("s2_count",  32'(out_count),  32'd4);
    handshake();

    // 3: delete key, then delete to empty
    key(4'h7); key(4'h8); key(4'hA); key(4'h9); key(4'hF);
    chk("s3_digits", 32'(out_digits), 32'h0079);
    chk("s3_count",  32'(out_count),  32'd2);
    handshake();
    key(4'h5); key(4'hA);
    chk("s3_idle_busy", 32'(busy), 32'd0);
    key(4'hF);
    chk("s3_no_valid", 32'(out_valid), 32'd0);

    // 4: clear, then letters in idle
    key(4'h4); key(4'hE);
    chk("s4_busy", 32'(busy), 32'd0);
    key(4'hF);
    chk("s4_no_valid", 32'(out_valid), 32'd0);
    key(4'hB);
    chk("s4_b_busy", 32'(busy), 32'd0);

    // 5: idle timeout, then key held through reset
    to_before = to_total;
    key(4'h6);
    repeat (20) tick();
    chk("s5_to_pulses", 32'(to_total - to_before), 32'd1);
    chk("s5_busy", 32'(busy), 32'd0);
    bcd_in = 4'h3; key_valid = 1'b1;
    rst = 1'b1; tick(); tick();
    rst = 1'b0; repeat (3) tick();
    chk("s5_held_busy", 32'(busy), 32'd0);
    key_valid = 1'b0; repeat (3) tick();
    key(4'h2);
    chk("s5_repress_busy", 32'(busy), 32'd1);
    key(4'hE);

    // 6: reset while delivering, keys during delivery dropped
    key(4'h3); key(4'hF);
    key(4'h5); key(4'h6);
    chk("s6_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_count", 32'(out_count), 32'd0);
    chk("s6_busy",  32'(busy),      32'd0);
    tick();
    key(4'h8); key(4'hF);
    chk("s6_digits", 32'(out_digits), 32'h0008);
    chk("s6_cnt1",   32'(out_count),  32'd1);
    handshake();

    // Randomized key traffic with random consumer readiness
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rcode = 4'($urandom_range(0, 9));
        5:             rcode = 4'hA;
        6:             rcode = 4'hE;
        7, 8:          rcode = 4'hF;
        default:       rcode = 4'($urandom_range(11, 13));
      endcase
      press(rcode, $urandom_range(1, 3), $urandom_range(1, 4));
      if ($urandom_range(0, 19) == 0) repeat (TO + 2) tick();
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
    end
    rand_ready = 0;
    out_ready  = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
